point_cursor_controller: RTL and testbench
==========================================

POINT_CURSOR_CONTROLLER -- requirements
Module: point_cursor_controller

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of display digits (2..16, any integer, need not be a power of two).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, clock cycles from press to first auto-repeat move (>=2).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, clock cycles between subsequent auto-repeat moves (>=1).
REQ-004 SHALL have parameter BLINK_PERIOD, default 12500000, cycles per blink half-period (>=1); CW = clog2(DIGITS) is a derived localparam.
REQ-005 SHALL have clock  input  1  single clock; all state on rising edge.
REQ-006 SHALL have resetN  input  1  asynchronous active-low reset.
REQ-007 SHALL have leftHeld, rightHeld, toggleHeld  input  1 each  debounced, clock-synchronous button levels.
REQ-008 SHALL have exclusiveMode  input  1  1 = at most one point lit; 0 = independent points.
REQ-009 SHALL have clearAll  input  1  synchronous clear of all points.
REQ-010 SHALL have blinkEnable  input  1  enables cursor blink blanking.
REQ-011 SHALL have pointEnable  output  DIGITS  registered per-digit decimal-point enables.
REQ-012 SHALL have cursor  output  CW  registered selected digit index; cursorOneHot  output  DIGITS  = 1 << cursor.
REQ-013 SHALL have blankMask  output  DIGITS  digits to blank for blink (for the downstream display controller).

Function
REQ-014 SHALL detect rising edges as level high this cycle and low in the previous-cycle sample register; responses register on that same edge (visible one cycle after level first sampled high).
REQ-015 SHALL define a left move as cursor+1 with DIGITS-1 wrapping to 0, and a right move as cursor-1 with 0 wrapping to DIGITS-1.
REQ-016 SHALL implement repeat FSM IDLE/DELAY/REPEAT with one cycle counter; "solo" = exactly one of leftHeld/rightHeld high.
REQ-017 IDLE: SHALL, on a rising edge of a solo button, move once, latch direction, clear counter, go DELAY.
REQ-018 DELAY: SHALL go IDLE without moving if latched button low or both held; SHALL, at counter = REPEAT_DELAY-1, move, clear counter, go REPEAT.
REQ-019 REPEAT: SHALL move every REPEAT_PERIOD cycles while latched button solo-held; SHALL go IDLE otherwise.
REQ-020 SHALL NOT move when both left and right rise or are held in the same cycle.
REQ-021 SHALL, on toggleHeld rising edge with exclusiveMode=0, invert pointEnable[cursor].
REQ-022 SHALL, on toggle rising edge with exclusiveMode=1, set pointEnable to 0 if bit cursor was set, else to cursorOneHot.
REQ-023 SHALL apply toggle to the pre-move cursor when a toggle and a move occur in the same cycle.
REQ-024 SHALL clear pointEnable when clearAll=1, overriding any same-cycle toggle.
REQ-025 SHALL clear pointEnable on the cycle after exclusiveMode is sampled rising 0->1; a same-cycle toggle is discarded.
REQ-026 SHALL toggle blinkPhase every BLINK_PERIOD cycles; any cursor move SHALL restart the counter at 0 with blinkPhase=1.
REQ-027 SHALL drive blankMask = cursorOneHot when blinkEnable=1 and blinkPhase=0, else all zeros (combinational from registers).

Reset
REQ-028 SHALL, on resetN low, immediately force cursor=0, pointEnable=0, FSM=IDLE, counters=0, blinkPhase=1, blankMask=0.
REQ-029 SHALL reset previous-sample registers of left/right/toggle and exclusiveMode to 1, so inputs held through reset act only after release and re-press.
REQ-030 SHALL abandon any repeat sequence when reset asserts mid-operation; no move on reset release.

Verification (DIGITS=6, REPEAT_DELAY=4, REPEAT_PERIOD=2, BLINK_PERIOD=3)
REQ-031 Wrap: cursor=5, one left pulse -> cursor=0; one right pulse -> cursor=5; cursorOneHot 6'b100000.
REQ-032 Auto-repeat: hold left 10 cycles from cursor=0 -> moves on edge 0, 4, 6, 8; cursor=4; release -> IDLE, no further moves.
REQ-033 Simultaneous: left and right rise together -> cursor unchanged, FSM IDLE; releasing right while left held -> no move until left re-pressed.
REQ-034 Toggle modes: exclusiveMode=0, toggle at cursor 1 and 3 -> pointEnable=6'b001010; raise exclusiveMode -> 0; toggle at 2 -> 6'b000100; toggle again -> 0.
REQ-035 Priority: toggle + clearAll same cycle -> pointEnable=0; toggle + left at cursor=2 -> bit 2 toggled, cursor=3.
REQ-036 Reset/blink: left held across resetN release -> no move; blinkEnable=1 -> blankMask=0 for 3 cycles, cursorOneHot for 3; move mid-blink -> blankMask=0 for next 3 cycles.

Source files
------------

// File: rtl/point_cursor_controller_if.sv
// Button/control and display-side signal bundle for point_cursor_controller.
//   slave  : seen by the controller (button levels and mode controls in,
//            point enables, cursor and blink mask out)
//   master : seen by whatever drives the buttons and consumes the outputs
// Signals:
//   leftHeld, rightHeld, toggleHeld : debounced, clock-synchronous button levels
//   exclusiveMode                   : 1 = at most one point lit
//   clearAll                        : synchronous clear of all points
//   blinkEnable                     : enables cursor blink blanking
//   pointEnable [DIGITS]            : per-digit decimal-point enables
//   cursor [CW]                     : selected digit index
//   cursorOneHot [DIGITS]           : 1 << cursor
//   blankMask [DIGITS]              : digits to blank during the blink-off phase
interface point_cursor_controller_if #(
    parameter int unsigned DIGITS = 8
);
    localparam int unsigned CW = $clog2(DIGITS);

    logic              leftHeld;
    logic              rightHeld;
    logic              toggleHeld;
    logic              exclusiveMode;
    logic              clearAll;
    logic              blinkEnable;
    logic [DIGITS-1:0] pointEnable;
    logic [CW-1:0]     cursor;
    logic [DIGITS-1:0] cursorOneHot;
    logic [DIGITS-1:0] blankMask;

    modport slave (
        input  leftHeld,
        input  rightHeld,
        input  toggleHeld,
        input  exclusiveMode,
        input  clearAll,
        input  blinkEnable,
        output pointEnable,
        output cursor,
        output cursorOneHot,
        output blankMask
    );

    modport master (
        output leftHeld,
        output rightHeld,
        output toggleHeld,
        output exclusiveMode,
        output clearAll,
        output blinkEnable,
        input  pointEnable,
        input  cursor,
        input  cursorOneHot,
        input  blankMask
    );
endinterface

// File: rtl/point_cursor_controller.sv
// Decimal-point cursor controller for a multi-digit display.
// Left/right buttons move a cursor across DIGITS positions (with wrap and
// press-and-hold auto-repeat); the toggle button lights or clears the decimal
// point under the cursor, either independently per digit or exclusively.
// The cursor digit can blink via blankMask.
// Ports:
//   clock  : single clock, all state on rising edge
//   resetN : asynchronous active-low reset
//   bus    : point_cursor_controller_if.slave (buttons/modes in, display out)
module point_cursor_controller #(
    parameter int unsigned DIGITS        = 8,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned BLINK_PERIOD  = 12500000
) (
    input  logic                        clock,
    input  logic                        resetN,
    point_cursor_controller_if.slave    bus
);
    localparam int unsigned CW      = $clog2(DIGITS);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RW      = $clog2(RPT_MAX + 1);
    localparam int unsigned BW      = $clog2(BLINK_PERIOD + 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_t;

    state_t            stateQ, stateD;
    logic [RW-1:0]     rptCntQ, rptCntD;
    logic              dirLeftQ, dirLeftD;
    logic [CW-1:0]     cursorQ, cursorD;
    logic [DIGITS-1:0] pointQ, pointD;
    logic [BW-1:0]     blinkCntQ, blinkCntD;
    logic              blinkPhaseQ, blinkPhaseD;
    logic              leftPrevQ, rightPrevQ, togglePrevQ, exclPrevQ;

    logic              move, moveLeft;
    logic [DIGITS-1:0] oneHot;

    wire leftRise   = bus.leftHeld & ~leftPrevQ;
    wire rightRise  = bus.rightHeld & ~rightPrevQ;
    wire toggleRise = bus.toggleHeld & ~togglePrevQ;
    wire exclRise   = bus.exclusiveMode & ~exclPrevQ;
    wire solo       = bus.leftHeld ^ bus.rightHeld;
    // The latched button must still be the only one held to keep repeating.
    wire latchedSolo = solo & (dirLeftQ ? bus.leftHeld : bus.rightHeld);

    assign oneHot = DIGITS'(1) << cursorQ;

    // Repeat FSM: one shared counter for the initial delay and the period.
    always_comb begin
        stateD   = stateQ;
        rptCntD  = rptCntQ;
        dirLeftD = dirLeftQ;
        move     = 1'b0;
        moveLeft = dirLeftQ;
        unique case (stateQ)
            StIdle: begin
                if (leftRise && !bus.rightHeld) begin
                    move     = 1'b1;
                    moveLeft = 1'b1;
                    dirLeftD = 1'b1;
                    rptCntD  = '0;
                    stateD   = StDelay;
                end else if (rightRise && !bus.leftHeld) begin
                    move     = 1'b1;
                    moveLeft = 1'b0;
                    dirLeftD = 1'b0;
                    rptCntD  = '0;
                    stateD   = StDelay;
                end
            end
            StDelay: begin
                if (!latchedSolo) begin
                    rptCntD = '0;
                    stateD  = StIdle;
                end else if (rptCntQ == RW'(REPEAT_DELAY - 1)) begin
                    move    = 1'b1;
                    rptCntD = '0;
                    stateD  = StRepeat;
                end else begin
                    rptCntD = rptCntQ + 1'b1;
                end
            end
            StRepeat: begin
                if (!latchedSolo) begin
                    rptCntD = '0;
                    stateD  = StIdle;
                end else if (rptCntQ == RW'(REPEAT_PERIOD - 1)) begin
                    move    = 1'b1;
                    rptCntD = '0;
                end else begin
                    rptCntD = rptCntQ + 1'b1;
                end
            end
            default: begin
                rptCntD = '0;
                stateD  = StIdle;
            end
        endcase
    end

    // Cursor, point enables and blink timer.
    always_comb begin
        cursorD     = cursorQ;
        pointD      = pointQ;
        blinkCntD   = blinkCntQ;
        blinkPhaseD = blinkPhaseQ;

        if (move) begin
            if (moveLeft) begin
                cursorD = (cursorQ == CW'(DIGITS - 1)) ? '0 : cursorQ + 1'b1;
            end else begin
                cursorD = (cursorQ == '0) ? CW'(DIGITS - 1) : cursorQ - 1'b1;
            end
        end

        // Toggle always acts on the pre-move cursor (oneHot is from cursorQ).
        if (bus.clearAll || exclRise) begin
            pointD = '0;
        end else if (toggleRise) begin
            if (bus.exclusiveMode) begin
                pointD = (|(pointQ & oneHot)) ? '0 : oneHot;
            end else begin
                pointD = pointQ ^ oneHot;
            end
        end

        // A move restarts the blink so the new cursor is shown first.
        if (move) begin
            blinkCntD   = '0;
            blinkPhaseD = 1'b1;
        end else if (blinkCntQ == BW'(BLINK_PERIOD - 1)) begin
            blinkCntD   = '0;
            blinkPhaseD = ~blinkPhaseQ;
        end else begin
            blinkCntD = blinkCntQ + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stateQ      <= StIdle;
            rptCntQ     <= '0;
            dirLeftQ    <= 1'b0;
            cursorQ     <= '0;
            pointQ      <= '0;
            blinkCntQ   <= '0;
            blinkPhaseQ <= 1'b1;
            // Previous samples reset high so buttons held through reset need a re-press.
            leftPrevQ   <= 1'b1;
            rightPrevQ  <= 1'b1;
            togglePrevQ <= 1'b1;
            exclPrevQ   <= 1'b1;
        end else begin
            stateQ      <= stateD;
            rptCntQ     <= rptCntD;
            dirLeftQ    <= dirLeftD;
            cursorQ     <= cursorD;
            pointQ      <= pointD;
            blinkCntQ   <= blinkCntD;
            blinkPhaseQ <= blinkPhaseD;
            leftPrevQ   <= bus.leftHeld;
            rightPrevQ  <= bus.rightHeld;
            togglePrevQ <= bus.toggleHeld;
            exclPrevQ   <= bus.exclusiveMode;
        end
    end

    assign bus.pointEnable  = pointQ;
    assign bus.cursor       = cursorQ;
    assign bus.cursorOneHot = oneHot;
    assign bus.blankMask    = (bus.blinkEnable && !blinkPhaseQ) ? oneHot : '0;

endmodule

// File: tb/tb_point_cursor_controller.sv
// Directed bench for point_cursor_controller with DIGITS=6, REPEAT_DELAY=4,
// REPEAT_PERIOD=2, BLINK_PERIOD=3. Inputs change and outputs are sampled 1
// time unit after each rising clock edge.
module tb_point_cursor_controller;
    logic clock;
    logic resetN;
    int   tests;
    int   failures;

    point_cursor_controller_if #(.DIGITS(6)) bus ();

    point_cursor_controller #(
        .DIGITS        (6),
        .REPEAT_DELAY  (4),
        .REPEAT_PERIOD (2),
        .BLINK_PERIOD  (3)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic left_pulse();
        bus.leftHeld = 1'b1;
        tick(1);
        bus.leftHeld = 1'b0;
        tick(1);
    endtask

    task automatic right_pulse();
        bus.rightHeld = 1'b1;
        tick(1);
        bus.rightHeld = 1'b0;
        tick(1);
    endtask

    task automatic toggle_pulse();
        bus.toggleHeld = 1'b1;
        tick(1);
        bus.toggleHeld = 1'b0;
        tick(1);
    endtask

    initial begin
        tests             = 0;
        failures          = 0;
        resetN            = 1'b0;
        bus.leftHeld      = 1'b0;
        bus.rightHeld     = 1'b0;
        bus.toggleHeld    = 1'b0;
        bus.exclusiveMode = 1'b0;
        bus.clearAll      = 1'b0;
        bus.blinkEnable   = 1'b1;
        tick(2);

        // Reset state
        check("rst_cursor", 32'(bus.cursor), 32'd0);
        check("rst_points", 32'(bus.pointEnable), 32'd0);
        check("rst_onehot", 32'(bus.cursorOneHot), 32'b000001);
        check("rst_blank", 32'(bus.blankMask), 32'd0);
        bus.blinkEnable = 1'b0;
        resetN = 1'b1;
        tick(2);

        // Wrap
        repeat (5) left_pulse();
        check("walk_to_5", 32'(bus.cursor), 32'd5);
        left_pulse();
        check("wrap_left", 32'(bus.cursor), 32'd0);
        right_pulse();
        check("wrap_right", 32'(bus.cursor), 32'd5);
        check("wrap_onehot", 32'(bus.cursorOneHot), 32'b100000);
        left_pulse();
        check("back_to_0", 32'(bus.cursor), 32'd0);

        // Auto-repeat: moves on edges 0, 4, 6, 8
        bus.leftHeld = 1'b1;
        tick(1);
        check("rpt_edge0", 32'(bus.cursor), 32'd1);
        tick(3);
        check("rpt_edge3", 32'(bus.cursor), 32'd1);
        tick(1);
        check("rpt_edge4", 32'(bus.cursor), 32'd2);
        tick(1);
        check("rpt_edge5", 32'(bus.cursor), 32'd2);
        tick(1);
        check("rpt_edge6", 32'(bus.cursor), 32'd3);
        tick(2);
        check("rpt_edge8", 32'(bus.cursor), 32'd4);
        tick(1);
        check("rpt_edge9", 32'(bus.cursor), 32'd4);
        bus.leftHeld = 1'b0;
        tick(5);
        check("rpt_release", 32'(bus.cursor), 32'd4);

        // Simultaneous press
        bus.leftHeld  = 1'b1;
        bus.rightHeld = 1'b1;
        tick(1);
        check("both_rise", 32'(bus.cursor), 32'd4);
        tick(5);
        check("both_held", 32'(bus.cursor), 32'd4);
        bus.rightHeld = 1'b0;
        tick(6);
        check("left_left_held", 32'(bus.cursor), 32'd4);
        bus.leftHeld = 1'b0;
        tick(1);
        left_pulse();
        check("left_repress", 32'(bus.cursor), 32'd5);

        // Toggle modes
        left_pulse();
        left_pulse();
        toggle_pulse();
        check("tog_at_1", 32'(bus.pointEnable), 32'b000010);
        left_pulse();
        left_pulse();
        toggle_pulse();
        check("tog_at_3", 32'(bus.pointEnable), 32'b001010);
        bus.exclusiveMode = 1'b1;
        tick(1);
        check("excl_rise_clr", 32'(bus.pointEnable), 32'd0);
        right_pulse();
        toggle_pulse();
        check("excl_tog_2", 32'(bus.pointEnable), 32'b000100);
        toggle_pulse();
        check("excl_tog_off", 32'(bus.pointEnable), 32'd0);

        // Priority
        toggle_pulse();
        check("excl_tog_on", 32'(bus.pointEnable), 32'b000100);
        bus.toggleHeld = 1'b1;
        bus.clearAll   = 1'b1;
        tick(1);
        check("clear_wins", 32'(bus.pointEnable), 32'd0);
        bus.toggleHeld = 1'b0;
        bus.clearAll   = 1'b0;
        bus.exclusiveMode = 1'b0;
        tick(1);
        bus.toggleHeld = 1'b1;
        bus.leftHeld   = 1'b1;
        tick(1);
        check("tog_move_pts", 32'(bus.pointEnable), 32'b000100);
        check("tog_move_cur", 32'(bus.cursor), 32'd3);
        bus.toggleHeld = 1'b0;
        bus.leftHeld   = 1'b0;
        tick(1);
        bus.exclusiveMode = 1'b1;
        bus.toggleHeld    = 1'b1;
        tick(1);
        check("excl_rise_tog", 32'(bus.pointEnable), 32'd0);
        bus.toggleHeld    = 1'b0;
        tick(1);
        bus.exclusiveMode = 1'b0;
        tick(1);

        // Reset with left held, then blink
        bus.leftHeld = 1'b1;
        resetN = 1'b0;
        #1;
        check("async_rst_cur", 32'(bus.cursor), 32'd0);
        tick(1);
        resetN = 1'b1;
        tick(3);
        check("held_thru_rst", 32'(bus.cursor), 32'd0);
        bus.leftHeld = 1'b0;
        tick(1);

        bus.blinkEnable = 1'b1;
        bus.leftHeld = 1'b1;
        tick(1);
        check("blink_e0", 32'(bus.blankMask), 32'd0);
        bus.leftHeld = 1'b0;
        tick(1);
        check("blink_e1", 32'(bus.blankMask), 32'd0);
        tick(1);
        check("blink_e2", 32'(bus.blankMask), 32'd0);
        tick(1);
        check("blink_e3", 32'(bus.blankMask), 32'b000010);
        tick(1);
        check("blink_e4", 32'(bus.blankMask), 32'b000010);
        bus.leftHeld = 1'b1;
        tick(1);
        check("blink_move", 32'(bus.blankMask), 32'd0);
        check("blink_cur", 32'(bus.cursor), 32'd2);
        bus.leftHeld = 1'b0;
        tick(1);
        check("blink_m1", 32'(bus.blankMask), 32'd0);
        tick(1);
        check("blink_m2", 32'(bus.blankMask), 32'd0);
        tick(1);
        check("blink_m3", 32'(bus.blankMask), 32'b000100);
        bus.blinkEnable = 1'b0;
        #1;
        check("blink_off", 32'(bus.blankMask), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
